// File: rtl/fetch_prefetch_queue_if.sv
// ----------------------------------------------------------------------------
// fetch_prefetch_queue_if
//
// Bundles the ROM read port, the execute redirect, the fetch halt and the
// decode valid/ready handshake of the instruction prefetch queue.
//
//   master : the prefetch queue itself (drives rom_req/rom_addr, instr_*, count)
//   slave  : the surrounding pipeline (ROM, execute, decode)
//
// Signals
//   rom_req        ROM read issued this cycle
//   rom_addr       ROM read address (untranslated PC)
//   rom_data       ROM word, valid the cycle after rom_req
//   redirect_valid branch taken in execute
//   redirect_pc    branch target
//   fetch_halt     suppresses new ROM requests while high
//   instr_valid    head entry available to decode
//   instr_data     head instruction word
//   instr_pc       PC of the head instruction
//   instr_ready    decode accepts the head entry
//   count          current FIFO occupancy
// ----------------------------------------------------------------------------
interface fetch_prefetch_queue_if #(
   parameter int PC_W   = 12,
   parameter int DATA_W = 15,
   parameter int DEPTH  = 4
);
   localparam int CNT_W = $clog2(DEPTH + 1);

   logic              rom_req;
   logic [PC_W-1:0]   rom_addr;
   logic [DATA_W-1:0] rom_data;
   logic              redirect_valid;
   logic [PC_W-1:0]   redirect_pc;
   logic              fetch_halt;
   logic              instr_valid;
   logic [DATA_W-1:0] instr_data;
   logic [PC_W-1:0]   instr_pc;
   logic              instr_ready;
   logic [CNT_W-1:0]  count;

   modport master (
      output rom_req, rom_addr, instr_valid, instr_data, instr_pc, count,
      input  rom_data, redirect_valid, redirect_pc, fetch_halt, instr_ready
   );

   modport slave (
      input  rom_req, rom_addr, instr_valid, instr_data, instr_pc, count,
      output rom_data, redirect_valid, redirect_pc, fetch_halt, instr_ready
   );
endinterface

// File: rtl/fetch_prefetch_queue.sv
// ----------------------------------------------------------------------------
// fetch_prefetch_queue
//
// Decoupled instruction-fetch front end. Issues sequential PC reads to a
// synchronous ROM, buffers each returned word together with its PC in a
// DEPTH-entry FIFO and hands entries to decode over a valid/ready handshake.
// A redirect from execute flushes buffered and in-flight fetches and restarts
// fetch at the branch target. Banking/translation lives outside this block.
//
// Ports
//   clock   clock
//   rst_l   asynchronous, active-low reset
//   bus     fetch_prefetch_queue_if.master (ROM port, redirect, halt, decode
//           handshake, occupancy)
//
// Build option
//   FETCH_BYPASS_EN  when defined, a word returning into an empty FIFO is
//                    presented to decode combinationally and, if accepted in
//                    that cycle, never written to the FIFO (2-cycle
//                    redirect/reset-to-valid instead of 3).
// ----------------------------------------------------------------------------
module fetch_prefetch_queue #(
   parameter int              PC_W     = 12,
   parameter int              DATA_W   = 15,
   parameter int              DEPTH    = 4,
   parameter logic [PC_W-1:0] RESET_PC = PC_W'('o4000)
) (
   input logic                    clock,
   input logic                    rst_l,
   fetch_prefetch_queue_if.master bus
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH + 1);

   typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;

   state_t            state_q;
   logic [PC_W-1:0]   fetch_pc_q, fetch_pc_d;
   logic              inflight_q;
   logic              kill_q;
   logic [PC_W-1:0]   inflight_pc_q;
   logic [PTR_W-1:0]  head_q, tail_q;
   logic [CNT_W-1:0]  count_q, count_d;
   logic [DATA_W-1:0] mem_data_q [DEPTH];
   logic [PC_W-1:0]   mem_pc_q   [DEPTH];

   logic [CNT_W:0]    used;
   logic              issue, ret, push, pop, fifo_vld, byp, byp_take;

   always_comb begin
      // Words already buffered plus the one on its way back; a new request is
      // only issued when it is guaranteed a FIFO slot.
      used     = {1'b0, count_q} + {{CNT_W{1'b0}}, inflight_q};
      issue    = (state_q == RUN) && !bus.fetch_halt && !bus.redirect_valid &&
                 (used < (CNT_W+1)'(DEPTH));
      ret      = inflight_q && !kill_q;
      fifo_vld = (count_q != '0);
`ifdef FETCH_BYPASS_EN
      byp      = ret && !fifo_vld;
      byp_take = byp && bus.instr_ready;
`else
      byp      = 1'b0;
      byp_take = 1'b0;
`endif
      // A returning word is dropped when a redirect flushes in the same cycle.
      push       = ret && !bus.redirect_valid && !byp_take;
      pop        = fifo_vld && bus.instr_ready;
      count_d    = count_q + CNT_W'(push) - CNT_W'(pop);
      fetch_pc_d = fetch_pc_q + PC_W'(1);
   end

   assign bus.rom_req  = issue;
   assign bus.rom_addr = fetch_pc_q;
   assign bus.count    = count_q;

   // Outputs read as zero when nothing is presented so decode never sees
   // stale storage contents.
   always_comb begin
      bus.instr_valid = fifo_vld || byp;
      bus.instr_data  = '0;
      bus.instr_pc    = '0;
      if (fifo_vld) begin
         bus.instr_data = mem_data_q[head_q];
         bus.instr_pc   = mem_pc_q[head_q];
      end
`ifdef FETCH_BYPASS_EN
      else if (byp) begin
         bus.instr_data = bus.rom_data;
         bus.instr_pc   = inflight_pc_q;
      end
`endif
   end

   // Control state: FSM, fetch PC, in-flight tracking and FIFO pointers.
   always_ff @(posedge clock or negedge rst_l) begin
      if (!rst_l) begin
         state_q    <= IDLE;
         fetch_pc_q <= RESET_PC;
         count_q    <= '0;
         head_q     <= '0;
         tail_q     <= '0;
         inflight_q <= 1'b0;
         kill_q     <= 1'b0;
      end else begin
         kill_q <= bus.redirect_valid;
         if (bus.redirect_valid) begin
            state_q    <= bus.fetch_halt ? HOLD : RUN;
            fetch_pc_q <= bus.redirect_pc;
            count_q    <= '0;
            head_q     <= '0;
            tail_q     <= '0;
            inflight_q <= 1'b0;
         end else begin
            case (state_q)
               IDLE:    state_q <= RUN;
               RUN:     if (bus.fetch_halt)  state_q <= HOLD;
               HOLD:    if (!bus.fetch_halt) state_q <= RUN;
               default: state_q <= IDLE;
            endcase
            inflight_q <= issue;
            if (issue) fetch_pc_q <= fetch_pc_d;
            if (push)  tail_q     <= tail_q + PTR_W'(1);
            if (pop)   head_q     <= head_q + PTR_W'(1);
            count_q <= count_d;
         end
      end
   end

   // Datapath storage; contents are only observed through count, so no reset.
   always_ff @(posedge clock) begin
      if (issue) inflight_pc_q <= fetch_pc_q;
      if (push) begin
         mem_data_q[tail_q] <= bus.rom_data;
         mem_pc_q[tail_q]   <= inflight_pc_q;
      end
   end
endmodule

// File: doc/fetch_prefetch_queue.md
Name: fetch_prefetch_queue

Overview:
Decoupled instruction-fetch front end for the AGC pipeline. It issues sequential 12-bit PC reads to the synchronous ROM port and buffers the returned words, each tagged with its PC, in a DEPTH-entry FIFO. Decode drains the FIFO through a valid/ready handshake. A branch redirect from execute flushes all buffered and in-flight fetches and restarts fetch at the target. Address translation (FB/EB banking) stays outside this block; rom_addr is the untranslated PC.

Parameters:
PC_W, 12, PC / ROM address width.
DATA_W, 15, instruction word width.
DEPTH, 4, FIFO entries; must be a power of 2 and at least 2.
RESET_PC, 'o4000, first fetch address after reset.

Ports:
clock  input  1  clock.
rst_l  input  1  reset, asynchronous, active-low.
rom_req  output  1  ROM read issued this cycle.
rom_addr  output  PC_W  ROM read address; equals fetch_pc.
rom_data  input  DATA_W  ROM word; valid the cycle after rom_req.
redirect_valid  input  1  branch taken in execute.
redirect_pc  input  PC_W  branch target.
fetch_halt  input  1  suppresses new ROM requests while high.
instr_valid  output  1  head entry available.
instr_data  output  DATA_W  head instruction word.
instr_pc  output  PC_W  PC of the head instruction.
instr_ready  input  1  decode accepts the head entry.
count  output  $clog2(DEPTH+1)  current FIFO occupancy.

Behaviour:
- Reset values: fetch_pc=RESET_PC, count=0, inflight=0, rom_req=0, instr_valid=0, instr_data=0, instr_pc=0, state=IDLE.
- States:
  - IDLE: the single cycle after reset release; goes to RUN.
  - RUN: normal fetching.
  - HOLD: entered while fetch_halt=1 in RUN; returns to RUN when fetch_halt=0.
  - redirect_valid in any state forces RUN next cycle, unless fetch_halt is still high, in which case the next state is HOLD.
- Issue rule: rom_req=1 iff state==RUN, !fetch_halt, !redirect_valid, and (count + inflight) < DEPTH. On issue, inflight<=1, inflight_pc<=fetch_pc, and fetch_pc<=fetch_pc+1 modulo 2^PC_W (wraps 'o7777 -> 0).
- Return: in the cycle after an issue, if inflight=1 and no kill, {rom_data, inflight_pc} is written at the tail. With no redirect, the issue rule guarantees the FIFO is never overrun, so no overflow case exists.
- Pop: on instr_valid & instr_ready, the head advances. A push and a pop in the same cycle leave count unchanged. instr_valid = (count != 0), and instr_data/instr_pc are driven from the head entry.
- Redirect (redirect_valid=1):
  - A pop handshake in the same cycle is treated as completed.
  - On the next edge: count<=0, head/tail<=0, fetch_pc<=redirect_pc.
  - Any inflight word is killed: kill<=1 for exactly one cycle, and rom_data is discarded in that cycle.
  - rom_req is 0 in the redirect cycle.
  - A redirect to the same PC as the head still flushes.
- Latency (no bypass): redirect at cycle 0 -> rom_req with rom_addr=target at cycle 1 -> word written at the end of cycle 2 -> instr_valid at cycle 3. First instr_valid after reset release also comes at cycle 3.
- Steady-state throughput: 1 word/cycle when instr_ready is held high.
- fetch_halt: in-flight data still lands, and the FIFO continues to drain.
- count saturates conceptually at DEPTH; the pointers are log2(DEPTH) bits and wrap naturally.
- Asynchronous reset mid-operation returns to the reset values immediately; ROM data arriving in the following cycle is ignored because inflight=0.

Optional Feature:
FETCH_BYPASS_EN
- Defined: when count==0, inflight=1 and no kill, the returning word is presented combinationally:
  - instr_valid=1, instr_data=rom_data, instr_pc=inflight_pc.
  - If instr_ready=1, the word is consumed without being written to the FIFO; otherwise it is written as usual.
  - Redirect-to-valid latency becomes 2 cycles, and reset-to-valid becomes 2 cycles.
- Undefined: no combinational path from rom_data to instr_*; the 3-cycle latency above applies.

Test Plan:
1. Reset release, instr_ready=1, ROM returns addr+'o100 -> rom_addr sequence 'o4000, 'o4001, ...; first instr_valid at cycle 3 with pc='o4000, data='o4100; thereafter one word per cycle.
2. instr_ready=0 with DEPTH=4 -> count reaches 4; rom_req stays 0 after 4 issues; no entry lost; assert ready -> pcs 'o4000..'o4003 emerge in order.
3. Redirect to 'o2345 while count=3 and one fetch in flight -> count=0 next cycle; the in-flight word is never seen at instr_*; the next instr_pc is 'o2345 at redirect+3 (redirect+2 with FETCH_BYPASS_EN).
4. fetch_pc='o7776, free-run -> rom_addr 'o7776, 'o7777, 0, 1; instr_pc follows the same wrap.
5. fetch_halt=1 for 5 cycles with one fetch in flight -> that word is queued, no rom_req during the halt, the FIFO drains to 0; deassert -> fetch resumes at the next sequential PC.
6. Assert rst_l=0 mid-stream with count=2 -> instr_valid=0, count=0, rom_addr='o4000 immediately; after release, the first delivered pc is 'o4000.
